// File: rtl/stage4.sv
// stage4 - MEM stage of the 5-stage pipeline.
//
// Purpose:
//   Takes the EX/MEM pipeline registers and performs loads and stores over a
//   variable-latency request/ready data-memory handshake. It also resolves the
//   branch redirect, stalls upstream while an access is outstanding, and
//   produces the MEM/WB registers that feed writeback and the EX forwarding
//   unit.
//
// Parameters:
//   MEM_TIMEOUT  maximum BUSY cycles to wait for dmemReady before the access
//                is abandoned
//   CNT_W        width of the timeout counter; must hold MEM_TIMEOUT
//
// Ports:
//   clk, rstn                       clock; asynchronous active-low reset
//   exmemRd/Alu/Reg2/Zero           EX/MEM destination, ALU result (address),
//                                   store data and zero flag
//   exmemBranchTarget               computed branch target
//   exmemMemCtrl                    [2]=Branch [1]=MemRead [0]=MemWrite
//   exmemWbCtrl                     [1]=MemtoReg [0]=RegWrite
//   dmemRdata, dmemReady            memory read data; access completes this cycle
//   dmemReq/We/Addr/Wdata           registered memory request (We: 1=store)
//   memStall                        hold EX/MEM registers and PC upstream
//   pcSrc, branchTarget             branch redirect
//   memFault                        sticky access fault, cleared only by reset
//   memwbRd/Alu/ReadData/WbCtrl     MEM/WB registers (WbCtrl[0] = RegWrite)
//
// Optional feature (macro STAGE4_MISALIGN_CHK_EN):
//   When defined, an access whose address has bits [1:0] != 0 is not issued.
//   It retires as a bubble and sets memFault. When undefined, every access is
//   issued unchecked.

module stage4 #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  exmemRd,
    input  logic [31:0] exmemAlu,
    input  logic [31:0] exmemReg2,
    input  logic        exmemZero,
    input  logic [31:0] exmemBranchTarget,
    input  logic [2:0]  exmemMemCtrl,
    input  logic [1:0]  exmemWbCtrl,
    input  logic [31:0] dmemRdata,
    input  logic        dmemReady,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWdata,
    output logic        memStall,
    output logic        pcSrc,
    output logic [31:0] branchTarget,
    output logic        memFault,
    output logic [4:0]  memwbRd,
    output logic [31:0] memwbAlu,
    output logic [31:0] memwbReadData,
    output logic [1:0]  memwbWbCtrl
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] toCnt;

    logic acc;
    logic isStore;
    logic misalign;
    logic expire;

    // Setting both MemRead and MemWrite is treated as a store.
    assign acc     = exmemMemCtrl[1] | exmemMemCtrl[0];
    assign isStore = exmemMemCtrl[0];

`ifdef STAGE4_MISALIGN_CHK_EN
    assign misalign = (exmemAlu[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Last BUSY cycle the stage may wait for ready.
    assign expire = (toCnt == CNT_W'(MEM_TIMEOUT - 1));

    // On the expiry cycle the stall is released, so the instruction retires as a NOP.
    always_comb begin
        memStall = 1'b0;
        case (state)
            IDLE:    memStall = acc && !misalign;
            BUSY:    memStall = !dmemReady && !expire;
            default: memStall = 1'b0;
        endcase
    end

    assign pcSrc        = exmemMemCtrl[2] & exmemZero & !memStall;
    assign branchTarget = exmemBranchTarget;

    // EX/MEM -> MEM/WB boundary, with the memory request register alongside.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            toCnt         <= '0;
            dmemReq       <= 1'b0;
            dmemWe        <= 1'b0;
            dmemAddr      <= '0;
            dmemWdata     <= '0;
            memFault      <= 1'b0;
            memwbRd       <= '0;
            memwbAlu      <= '0;
            memwbReadData <= '0;
            memwbWbCtrl   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!acc) begin
                        memwbRd       <= exmemRd;
                        memwbAlu      <= exmemAlu;
                        memwbReadData <= '0;
                        memwbWbCtrl   <= exmemWbCtrl;
                    end else if (misalign) begin
                        memwbWbCtrl <= '0;
                        memFault    <= 1'b1;
                    end else begin
                        memwbWbCtrl <= '0;
                        dmemReq     <= 1'b1;
                        dmemWe      <= isStore;
                        dmemAddr    <= exmemAlu;
                        dmemWdata   <= exmemReg2;
                        toCnt       <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmemReady) begin
                        // Inputs are held stable while stalled, so the
                        // registered dmemWe still describes this access.
                        if (!dmemWe) begin
                            memwbReadData <= dmemRdata;
                        end
                        memwbRd     <= exmemRd;
                        memwbAlu    <= exmemAlu;
                        memwbWbCtrl <= exmemWbCtrl;
                        dmemReq     <= 1'b0;
                        toCnt       <= '0;
                        state       <= IDLE;
                    end else if (expire) begin
                        dmemReq     <= 1'b0;
                        toCnt       <= '0;
                        memwbWbCtrl <= '0;
                        memFault    <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        toCnt       <= toCnt + 1'b1;
                        memwbWbCtrl <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage4.sv
// tb_stage4 - directed testbench for stage4.
//
// Linear sequence of directed steps with hand-computed expected values.
// Inputs change 1 time unit after the rising edge. Registered outputs are
// sampled 1 time unit after the edge. Combinational outputs are sampled
// 1 time unit after the inputs change.

module tb_stage4;

    localparam int T = 16;

    logic        clk;
    logic        rstn;
    logic [4:0]  exmemRd;
    logic [31:0] exmemAlu;
    logic [31:0] exmemReg2;
    logic        exmemZero;
    logic [31:0] exmemBranchTarget;
    logic [2:0]  exmemMemCtrl;
    logic [1:0]  exmemWbCtrl;
    logic [31:0] dmemRdata;
    logic        dmemReady;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic        memStall;
    logic        pcSrc;
    logic [31:0] branchTarget;
    logic        memFault;
    logic [4:0]  memwbRd;
    logic [31:0] memwbAlu;
    logic [31:0] memwbReadData;
    logic [1:0]  memwbWbCtrl;

    int cmpCnt = 0;
    int errCnt = 0;

    stage4 #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
        .clk(clk), .rstn(rstn),
        .exmemRd(exmemRd), .exmemAlu(exmemAlu), .exmemReg2(exmemReg2),
        .exmemZero(exmemZero), .exmemBranchTarget(exmemBranchTarget),
        .exmemMemCtrl(exmemMemCtrl), .exmemWbCtrl(exmemWbCtrl),
        .dmemRdata(dmemRdata), .dmemReady(dmemReady),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
        .dmemWdata(dmemWdata), .memStall(memStall), .pcSrc(pcSrc),
        .branchTarget(branchTarget), .memFault(memFault),
        .memwbRd(memwbRd), .memwbAlu(memwbAlu),
        .memwbReadData(memwbReadData), .memwbWbCtrl(memwbWbCtrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        exmemRd = '0; exmemAlu = '0; exmemReg2 = '0; exmemZero = 1'b0;
        exmemBranchTarget = '0; exmemMemCtrl = '0; exmemWbCtrl = '0;
        dmemRdata = '0; dmemReady = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_dmemReq", 32'(dmemReq), 32'd0);
        check("rst_memFault", 32'(memFault), 32'd0);
        check("rst_memwbWbCtrl", 32'(memwbWbCtrl), 32'd0);
        check("rst_memwbAlu", memwbAlu, 32'd0);
        check("rst_memStall", 32'(memStall), 32'd0);
        rstn = 1'b1;

        // Non-memory op: 1-cycle latency, no stall
        exmemRd = 5'd5; exmemAlu = 32'h1234; exmemWbCtrl = 2'b01; exmemMemCtrl = 3'b000;
        #1;
        check("alu_stall_pre", 32'(memStall), 32'd0);
        tick();
        check("alu_memwbAlu", memwbAlu, 32'h1234);
        check("alu_memwbRd", 32'(memwbRd), 32'd5);
        check("alu_memwbWbCtrl", 32'(memwbWbCtrl), 32'd1);
        check("alu_stall_post", 32'(memStall), 32'd0);

        // Load at 0x100; ready arrives in the 4th BUSY cycle
        exmemRd = 5'd7; exmemAlu = 32'h100; exmemWbCtrl = 2'b11; exmemMemCtrl = 3'b010;
        dmemRdata = 32'hDEADBEEF;
        #1;
        check("ld_idle_stall", 32'(memStall), 32'd1);
        check("ld_idle_req", 32'(dmemReq), 32'd0);
        tick();
        check("ld_b1_req", 32'(dmemReq), 32'd1);
        check("ld_b1_we", 32'(dmemWe), 32'd0);
        check("ld_b1_addr", dmemAddr, 32'h100);
        check("ld_b1_stall", 32'(memStall), 32'd1);
        check("ld_b1_bubble", 32'(memwbWbCtrl), 32'd0);
        tick();
        check("ld_b2_stall", 32'(memStall), 32'd1);
        check("ld_b2_bubble", 32'(memwbWbCtrl), 32'd0);
        tick();
        check("ld_b3_stall", 32'(memStall), 32'd1);
        check("ld_b3_req", 32'(dmemReq), 32'd1);
        tick();
        dmemReady = 1'b1;
        #1;
        check("ld_b4_stall", 32'(memStall), 32'd0);
        check("ld_b4_req", 32'(dmemReq), 32'd1);
        tick();
        dmemReady = 1'b0;
        check("ld_done_rdata", memwbReadData, 32'hDEADBEEF);
        check("ld_done_wbctrl", 32'(memwbWbCtrl), 32'd3);
        check("ld_done_rd", 32'(memwbRd), 32'd7);
        check("ld_done_req", 32'(dmemReq), 32'd0);

        // Store at 0x200; ready after one BUSY cycle
        exmemRd = 5'd0; exmemAlu = 32'h200; exmemReg2 = 32'hA5A5A5A5;
        exmemWbCtrl = 2'b00; exmemMemCtrl = 3'b001;
        #1;
        check("st_idle_stall", 32'(memStall), 32'd1);
        tick();
        check("st_b1_req", 32'(dmemReq), 32'd1);
        check("st_b1_we", 32'(dmemWe), 32'd1);
        check("st_b1_wdata", dmemWdata, 32'hA5A5A5A5);
        check("st_b1_addr", dmemAddr, 32'h200);
        tick();
        dmemReady = 1'b1;
        check("st_b2_we", 32'(dmemWe), 32'd1);
        check("st_b2_wdata", dmemWdata, 32'hA5A5A5A5);
        check("st_b2_req", 32'(dmemReq), 32'd1);
        tick();
        dmemReady = 1'b0;
        check("st_done_req", 32'(dmemReq), 32'd0);
        check("st_done_wbctrl", 32'(memwbWbCtrl), 32'd0);
        check("st_done_rdata_kept", memwbReadData, 32'hDEADBEEF);
        check("st_done_alu", memwbAlu, 32'h200);

        // Branch resolution
        exmemMemCtrl = 3'b100; exmemZero = 1'b1; exmemBranchTarget = 32'h40;
        exmemAlu = 32'h0; exmemWbCtrl = 2'b00;
        #1;
        check("br_taken", 32'(pcSrc), 32'd1);
        check("br_target", branchTarget, 32'h40);
        exmemZero = 1'b0;
        #1;
        check("br_not_taken", 32'(pcSrc), 32'd0);
        tick();

        // Timeout: ready never arrives
        exmemRd = 5'd9; exmemAlu = 32'h300; exmemWbCtrl = 2'b11; exmemMemCtrl = 3'b010;
        tick();
        for (int i = 1; i < T; i++) begin
            check($sformatf("to_b%0d_stall", i), 32'(memStall), 32'd1);
            tick();
        end
        check("to_expire_stall", 32'(memStall), 32'd0);
        check("to_expire_req", 32'(dmemReq), 32'd1);
        check("to_expire_fault_pre", 32'(memFault), 32'd0);
        tick();
        exmemMemCtrl = 3'b000; exmemWbCtrl = 2'b01; exmemAlu = 32'h55; exmemRd = 5'd3;
        check("to_req", 32'(dmemReq), 32'd0);
        check("to_fault", 32'(memFault), 32'd1);
        check("to_wbctrl", 32'(memwbWbCtrl), 32'd0);
        #1;
        check("to_stall", 32'(memStall), 32'd0);

        // Ready outside a request is ignored; fault stays sticky
        dmemReady = 1'b1;
        tick();
        dmemReady = 1'b0;
        check("idle_ready_req", 32'(dmemReq), 32'd0);
        check("idle_ready_alu", memwbAlu, 32'h55);
        check("idle_ready_rdata", memwbReadData, 32'd0);
        tick();
        check("fault_sticky", 32'(memFault), 32'd1);

        // Reset asserted in the middle of an access
        exmemRd = 5'd4; exmemAlu = 32'h400; exmemWbCtrl = 2'b11; exmemMemCtrl = 3'b010;
        tick();
        check("rb_b1_req", 32'(dmemReq), 32'd1);
        rstn = 1'b0;
        #1;
        check("rb_req", 32'(dmemReq), 32'd0);
        check("rb_fault", 32'(memFault), 32'd0);
        check("rb_addr", dmemAddr, 32'd0);
        check("rb_alu", memwbAlu, 32'd0);
        check("rb_wbctrl", 32'(memwbWbCtrl), 32'd0);
        exmemMemCtrl = 3'b000; exmemWbCtrl = 2'b01; exmemAlu = 32'h77; exmemRd = 5'd6;
        tick();
        rstn = 1'b1;
        #1;
        check("rb_idle_stall", 32'(memStall), 32'd0);
        tick();
        check("rb_idle_alu", memwbAlu, 32'h77);
        check("rb_idle_rd", 32'(memwbRd), 32'd6);

        // Misaligned load
        exmemRd = 5'd8; exmemAlu = 32'h102; exmemWbCtrl = 2'b11; exmemMemCtrl = 3'b010;
        #1;
`ifdef STAGE4_MISALIGN_CHK_EN
        check("mis_stall", 32'(memStall), 32'd0);
        tick();
        exmemMemCtrl = 3'b000;
        check("mis_req", 32'(dmemReq), 32'd0);
        check("mis_fault", 32'(memFault), 32'd1);
        check("mis_wbctrl", 32'(memwbWbCtrl), 32'd0);
`else
        check("mis_stall", 32'(memStall), 32'd1);
        tick();
        check("mis_req", 32'(dmemReq), 32'd1);
        check("mis_addr", dmemAddr, 32'h102);
        check("mis_fault", 32'(memFault), 32'd0);
        dmemReady = 1'b1;
        dmemRdata = 32'h0BADF00D;
        tick();
        dmemReady = 1'b0;
        exmemMemCtrl = 3'b000;
        check("mis_done_rdata", memwbReadData, 32'h0BADF00D);
        check("mis_done_wbctrl", 32'(memwbWbCtrl), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/stage4.md
Name: stage4

Overview:
- MEM stage of the 5-stage pipeline.
- Consumes the EX/MEM pipeline registers produced by stage3 and performs loads and stores over a variable-latency data-memory handshake.
- Resolves branch redirect, stalls upstream while an access is outstanding, and produces the MEM/WB registers for writeback and for the stage3 forwarding unit.

Parameters:
- MEM_TIMEOUT, 16: max BUSY cycles waiting for dmemReady before the access is aborted.
- CNT_W, 5: width of the timeout counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rstn  in  1  asynchronous, active-low reset.
- exmemRd  in  5  destination register from EX.
- exmemAlu  in  32  ALU result; also the memory address.
- exmemReg2  in  32  store data.
- exmemZero  in  1  ALU zero flag.
- exmemBranchTarget  in  32  computed branch target.
- exmemMemCtrl  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite.
- exmemWbCtrl  in  2  [1]=MemtoReg, [0]=RegWrite.
- dmemRdata  in  32  read data from memory.
- dmemReady  in  1  memory completes the access this cycle.
- dmemReq  out  1  access request.
- dmemWe  out  1  1=store, 0=load.
- dmemAddr  out  32  access address.
- dmemWdata  out  32  store data.
- memStall  out  1  upstream must hold the EX/MEM registers and PC.
- pcSrc  out  1  take branch.
- branchTarget  out  32  redirect PC.
- memFault  out  1  sticky timeout flag.
- memwbRd  out  5  writeback register.
- memwbAlu  out  32  ALU result forwarded to WB.
- memwbReadData  out  32  load data.
- memwbWbCtrl  out  2  WB controls; bit 0 feeds forwarding as memwbWb.

Behaviour:
- Reset:
  - Async on rstn=0: state=IDLE, counter=0.
  - All registered outputs are 0, including dmemReq and memFault.
  - dmemReq drops immediately even mid-access; no completion is recorded.
- Access: acc = MemRead | MemWrite. If both bits are set, it is treated as a store.
- FSM IDLE:
  - No acc: MEM/WB registers load {exmemRd, exmemAlu, 0, exmemWbCtrl} at the next edge. Latency is 1 cycle and there is no stall.
  - acc: memStall=1 combinationally; MEM/WB loads a bubble (memwbWbCtrl=0).
  - On acc, registered dmemReq=1, dmemWe, dmemAddr=exmemAlu and dmemWdata=exmemReg2 are set, and the FSM moves to BUSY.
- FSM BUSY:
  - dmemReq, dmemWe, dmemAddr and dmemWdata are held stable.
  - memStall = !dmemReady.
  - dmemReady=1 at an edge:
    - memwbReadData<=dmemRdata for loads; unchanged for stores.
    - memwbRd, memwbAlu and memwbWbCtrl load from exmem*.
    - dmemReq<=0, counter<=0, state<=IDLE.
  - Minimum access latency is 2 cycles: the IDLE cycle plus one BUSY cycle.
- Timeout:
  - The counter increments each BUSY cycle without ready.
  - When the counter reaches MEM_TIMEOUT-1 and ready is still 0: dmemReq<=0, state<=IDLE, MEM/WB loads a bubble, memFault<=1.
  - memStall deasserts on the expiry cycle so the instruction retires as a NOP.
  - memFault is cleared only by reset.
- Ready outside a request: dmemReady while dmemReq=0 is ignored.
- Branch: pcSrc = Branch & exmemZero & !memStall, combinational; branchTarget = exmemBranchTarget.
- Upstream contract: while memStall=1, exmem* inputs are stable. The stage assumes, and does not check, this.
- Forwarding: memwbRd and memwbWbCtrl[0] are valid the cycle after the MEM/WB load. A bubble always has memwbWbCtrl=0.

Optional Feature:
- Macro: STAGE4_MISALIGN_CHK_EN.
- Defined:
  - An acc in IDLE with exmemAlu[1:0]!=0 issues no request and does not stall.
  - MEM/WB loads a bubble and memFault<=1 (same sticky flag as timeout).
- Not defined: address bits [1:0] pass through unchecked and every acc is issued.

Test Plan:
- Non-mem op, rstn released, exmemAlu=0x1234, exmemRd=5, WbCtrl=01, MemCtrl=000 -> next cycle memwbAlu=0x1234, memwbRd=5, memwbWbCtrl=01, memStall never 1.
- Load, addr=0x100, dmemReady high 3 cycles after dmemReq, dmemRdata=0xDEADBEEF, WbCtrl=11:
  - dmemReq=1 and memStall=1 for 4 cycles.
  - Then memwbReadData=0xDEADBEEF, memwbWbCtrl=11, dmemReq=0.
  - Bubble (memwbWbCtrl=0) during the stall.
- Store, addr=0x200, data=0xA5A5A5A5, ready after 1 BUSY cycle -> dmemWe=1, dmemWdata=0xA5A5A5A5 stable while dmemReq=1; memwbWbCtrl=00 after completion.
- MEM_TIMEOUT=16, load with dmemReady held 0:
  - After 16 BUSY cycles dmemReq=0, memFault=1, memStall=0, memwbWbCtrl=0.
  - memFault stays 1 until rstn=0.
- Branch, MemCtrl=100, zero=1, target=0x40 -> pcSrc=1, branchTarget=0x40 in the same cycle; zero=0 -> pcSrc=0.
- rstn pulsed low during BUSY -> dmemReq=0 immediately, all outputs 0, state IDLE.
- With STAGE4_MISALIGN_CHK_EN: load addr=0x102 -> no dmemReq, memFault=1.
